// File: rtl/uio_rr_arbiter.sv
// uio_rr_arbiter: round-robin owner selection for the shared uio pin bank,
// with a per-grant hold limit and a one-cycle turnaround between owners.
module uio_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ena,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ-1:0]   i_rel,
  input  logic [8*N_REQ-1:0] i_drv_out,
  input  logic [8*N_REQ-1:0] i_drv_oe,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [1:0]         o_gnt_id,
  output logic               o_busy,
  output logic               o_timeout,
  output logic [7:0]         o_uio_out,
  output logic [7:0]         o_uio_oe
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [1:0]       r_gnt_id, w_gnt_id_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             w_found;
  logic [1:0]       w_pick;
  logic             w_rel_own, w_req_own, w_hold_end;

  function automatic logic [1:0] wrap_inc(input logic [1:0] v);
    logic [1:0] res;
    if (v == 2'(N_REQ - 1)) res = 2'd0;
    else                    res = v + 2'd1;
    return res;
  endfunction

  // Rotating-priority scan: first requester at or after r_ptr
  always_comb begin
    logic [1:0] idx;
    w_found = 1'b0;
    w_pick  = 2'd0;
    idx     = r_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && i_req[idx]) begin
        w_found = 1'b1;
        w_pick  = idx;
      end else begin
        w_found = w_found;
      end
      idx = wrap_inc(idx);
    end
  end

  // Only the owner's request and release bits matter during a grant
  assign w_rel_own  = |(i_rel & r_gnt);
  assign w_req_own  = |(i_req & r_gnt);
  assign w_hold_end = (r_cnt == HOLD_LAST);

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_ptr_nxt     = r_ptr;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_ena && w_found) begin
          w_gnt_nxt    = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
          w_gnt_id_nxt = w_pick;
          w_busy_nxt   = 1'b1;
          w_cnt_nxt    = {CW{1'b0}};
          w_state_nxt  = ST_GRANT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!i_ena || w_rel_own || !w_req_own || w_hold_end) begin
          // pulse only when the hold limit is the sole reason to end
          w_timeout_nxt = i_ena && !w_rel_own && w_req_own;
          w_gnt_nxt     = {N_REQ{1'b0}};
          w_busy_nxt    = 1'b0;
          w_ptr_nxt     = wrap_inc(r_gnt_id);
          w_state_nxt   = ST_TURN;
        end else begin
          w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_TURN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = {N_REQ{1'b0}};
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_gnt     <= {N_REQ{1'b0}};
      r_gnt_id  <= 2'd0;
      r_ptr     <= 2'd0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= {CW{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_ptr     <= w_ptr_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // Pin mux: one-hot grant selects the owner's slices, zero when idle
  always_comb begin
    o_uio_out = 8'h00;
    o_uio_oe  = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      o_uio_out = o_uio_out | ({8{r_gnt[i]}} & i_drv_out[8*i +: 8]);
      o_uio_oe  = o_uio_oe  | ({8{r_gnt[i]}} & i_drv_oe[8*i +: 8]);
    end
  end

  assign o_gnt     = r_gnt;
  assign o_gnt_id  = r_gnt_id;
  assign o_busy    = r_busy;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_uio_rr_arbiter.sv
// Self-checking bench for uio_rr_arbiter: owner/gap/hold-count reference model
// compared every cycle, plus directed literal checks and a random phase.
module tb_uio_rr_arbiter;
  localparam int N  = 4;
  localparam int MH = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [3:0]  rel = 4'd0;
  logic [31:0] drv_out = 32'd0;
  logic [31:0] drv_oe = 32'd0;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        busy, timeout;
  logic [7:0]  uio_out, uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: who owns the bus, for how long, and the turnaround gap
  int m_owner = -1;
  int m_last  = 0;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_turn  = 1'b0;
  bit m_tmo   = 1'b0;

  uio_rr_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_req(req), .i_rel(rel),
    .i_drv_out(drv_out), .i_drv_oe(drv_oe),
    .o_gnt(gnt), .o_gnt_id(gnt_id), .o_busy(busy), .o_timeout(timeout),
    .o_uio_out(uio_out), .o_uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = 0; m_ptr = 0; m_hold = 0; m_turn = 1'b0; m_tmo = 1'b0;
  endtask

  task automatic model_step();
    logic [1:0] o;
    if (!rst_n) begin
      model_reset();
    end else if (m_owner >= 0) begin
      o = m_owner[1:0];
      m_hold++;
      if (!ena || rel[o] || !req[o] || m_hold == MH) begin
        m_tmo   = ena && !rel[o] && req[o];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_turn  = 1'b1;
      end
    end else if (m_turn) begin
      m_turn = 1'b0;
      m_tmo  = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (ena && req != 4'd0) begin
        for (int i = 0; i < N; i++) begin
          int c;
          c = (m_ptr + i) % N;
          o = c[1:0];
          if (m_owner < 0 && req[o]) begin
            m_owner = c;
            m_last  = c;
            m_hold  = 0;
          end
        end
      end
    end
  endtask

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [3:0] e_gnt;
    logic [7:0] e_out, e_oe;
    if (m_owner >= 0) begin
      e_gnt = 4'b0001 << m_owner;
      e_out = drv_out[8*m_owner +: 8];
      e_oe  = drv_oe[8*m_owner +: 8];
    end else begin
      e_gnt = 4'd0;
      e_out = 8'd0;
      e_oe  = 8'd0;
    end
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("gnt_id", 32'(gnt_id), 32'(m_last[1:0]));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("timeout", 32'(timeout), 32'(m_tmo));
    chk("uio_out", 32'(uio_out), 32'(e_out));
    chk("uio_oe", 32'(uio_oe), 32'(e_oe));
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #3;
  endtask

  initial begin
    drv_out = $urandom;
    drv_oe  = $urandom | 32'h0000_0001;
    ena = 1'b1;
    req = 4'b1111;
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_oe", 32'(uio_oe), 32'd0);
    chk("rst_out", 32'(uio_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);

    rst_n = 1'b1;
    tick();
    chk("first_gnt", 32'(gnt), 32'h1);
    chk("first_oe", 32'(uio_oe), 32'(drv_oe[7:0]));

    // rotation 0,1,2,3,0: two-cycle grants, two-cycle gaps
    for (int g = 0; g < 5; g++) begin
      chk("rot_gnt", 32'(gnt), 32'(4'b0001 << (g % 4)));
      chk("rot_id", 32'(gnt_id), 32'(g % 4));
      tick();
      chk("rot_hold", 32'(gnt), 32'(4'b0001 << (g % 4)));
      rel = 4'b0001 << (g % 4);
      tick();
      rel = 4'd0;
      chk("rot_gap1", 32'(gnt), 32'd0);
      chk("rot_gap1_oe", 32'(uio_oe), 32'd0);
      tick();
      chk("rot_gap2", 32'(gnt), 32'd0);
      chk("rot_gap2_oe", 32'(uio_oe), 32'd0);
      tick();
    end

    // timeout: requester 2 alone, never releases
    req = 4'b0100;
    tick(); tick(); tick();
    chk("tmo_start", 32'(gnt), 32'h4);
    for (int c = 0; c < MH - 1; c++) begin
      tick();
      chk("tmo_held", 32'(gnt), 32'h4);
      chk("tmo_quiet", 32'(timeout), 32'd0);
    end
    tick();
    chk("tmo_drop", 32'(gnt), 32'd0);
    chk("tmo_pulse", 32'(timeout), 32'd1);
    tick();
    chk("tmo_clear", 32'(timeout), 32'd0);
    chk("tmo_gap", 32'(gnt), 32'd0);
    tick();
    chk("tmo_regrant", 32'(gnt), 32'h4);

    // release on the 15th grant cycle beats the timeout
    for (int c = 0; c < MH - 1; c++) tick();
    rel = 4'b0100;
    tick();
    rel = 4'd0;
    chk("relvt_drop", 32'(gnt), 32'd0);
    chk("relvt_notmo", 32'(timeout), 32'd0);
    tick();
    chk("relvt_notmo2", 32'(timeout), 32'd0);
    tick();
    chk("relvt_regrant", 32'(gnt), 32'h4);

    // stray non-owner release, then ena drop
    rel = 4'b1011;
    tick();
    rel = 4'd0;
    chk("stray_rel", 32'(gnt), 32'h4);
    ena = 1'b0;
    tick();
    chk("ena_drop", 32'(gnt), 32'd0);
    chk("ena_notmo", 32'(timeout), 32'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("ena_blocked", 32'(gnt), 32'd0);
      chk("ena_busy", 32'(busy), 32'd0);
    end
    ena = 1'b1;
    tick();
    chk("ena_regrant", 32'(gnt), 32'h4);
    chk("ena_regrant_id", 32'(gnt_id), 32'd2);

    // asynchronous reset between clock edges
    drv_out = 32'hA5A5_A5A5;
    drv_oe  = 32'hFFFF_FFFF;
    req = 4'b1111;
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_oe", 32'(uio_oe), 32'd0);
    chk("arst_out", 32'(uio_out), 32'd0);
    chk("arst_tmo", 32'(timeout), 32'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_first", 32'(gnt), 32'h1);

    // randomized traffic with sticky requests
    for (int t = 0; t < 3000; t++) begin
      ena = ($urandom_range(0, 15) != 0);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
      end
      rel = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
      drv_out = $urandom;
      drv_oe  = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uio_rr_arbiter.md
# uio_rr_arbiter

Round-robin arbiter that shares the 8-bit bidirectional `uio` pin bank of the tile between up to four internal requesters. It issues one-hot grants, limits how long any one requester may hold the bus, and inserts a bus-turnaround gap between owners. It sits between the tile's internal engines and the top-level `uio_out`/`uio_oe` ports.

## Interface
- `N_REQ`, 4: number of requesters; supported range 2..4.
- `MAX_HOLD`, 15: maximum number of consecutive cycles in one grant; must be ≥1.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset; asynchronous and active-low.
- `ena` in 1: tile enable.
  - Low blocks new grants.
  - Low ends an active grant.
- `req` in N_REQ: request level per requester; held high while bus access is wanted.
- `rel` in N_REQ: release strobe per requester; only the bit of the current owner is honoured.
- `drv_out` in 8*N_REQ: data each requester wants on the pins; requester i uses bits [8i+7:8i].
- `drv_oe` in 8*N_REQ: output-enable mask per requester, same slicing as `drv_out`.
- `gnt` out N_REQ: one-hot grant, registered.
- `gnt_id` out 2: index of the current owner, or of the last owner when idle; registered.
- `busy` out 1: high while any grant is active.
- `timeout` out 1: one-cycle pulse when a grant is revoked by the hold limit.
- `uio_out` out 8: `drv_out` slice of the owner; 0 when no grant.
- `uio_oe` out 8: `drv_oe` slice of the owner; 0 when no grant.

## Operation
- States: IDLE, GRANT, TURN.
- Reset values (asynchronous):
  - State IDLE.
  - `gnt`=0, `gnt_id`=0, `busy`=0, `timeout`=0, `uio_out`=0, `uio_oe`=0.
  - Round-robin pointer `ptr`=0.
  - Hold counter=0.
- IDLE:
  - If `ena`=1 and `req`≠0, select the first requester with `req` high, scanning `ptr`, `ptr`+1, … modulo N_REQ.
  - Load `gnt`, `gnt_id`, and `busy`=1; clear the hold counter; go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `uio_out`/`uio_oe` are a combinational mux of the owner's slices, gated by `gnt`.
  - The hold counter increments every cycle.
  - Exit conditions, checked at each edge, in priority order:
    1. `ena`=0
    2. `rel[owner]`=1
    3. `req[owner]`=0
    4. hold counter = MAX_HOLD−1 (timeout)
  - On exit: clear `gnt` and `busy`; set `ptr` = (owner+1) mod N_REQ; go to TURN.
  - `timeout` is set for one cycle only if exit reason 4 is the sole cause; release and timeout on the same edge give no pulse.
- TURN:
  - Exactly one cycle with `gnt`=0 and `uio_oe`=0; no arbitration is done in this cycle.
  - Then go to IDLE. `timeout` clears.
- `rel` and `req` bits of non-owners are ignored during GRANT. A requester whose `req` stays high keeps its place in the rotation.
- `ptr` advances only on grant end, never in IDLE.
- Counter width is $clog2(MAX_HOLD+1); it never wraps because it is cleared on every grant.
- `gnt` is always one-hot or zero, never multi-hot.

## Timing
- Request to grant: `req` sampled high in IDLE at edge k → `gnt` and `busy` high from edge k; the first bus cycle is k→k+1.
- Release: `rel` sampled at edge m → `gnt` low from edge m. The TURN cycle is m→m+1; IDLE evaluates at m+1; the earliest next grant is at edge m+2.
- Gap between owners: two cycles with `gnt`=0.
- Timeout: a grant loaded at edge k is dropped at edge k+MAX_HOLD, so it lasts exactly MAX_HOLD cycles. `timeout` is high for cycle k+MAX_HOLD→k+MAX_HOLD+1.
- `uio_out`/`uio_oe` follow `drv_*` of the owner with zero latency (combinational) and are zero whenever `gnt`=0.
- An `rst_n` assertion mid-grant drops `gnt`, `uio_oe`, and `timeout` immediately, without waiting for `clk`. After release the arbiter starts in IDLE with `ptr`=0.

## Test plan
- Reset/idle:
  - Hold `rst_n`=0, drive `req`=4'b1111 → all outputs 0.
  - Release reset with `ena`=1 → `gnt`=4'b0001 one edge later; `uio_oe` equals `drv_oe[7:0]`.
- Rotation:
  - `req`=4'b1111 held; each owner pulses `rel` one cycle after its grant.
  - → grant order 0,1,2,3,0. Each grant lasts 2 cycles, followed by exactly 2 idle cycles with `uio_oe`=0.
- Timeout:
  - `MAX_HOLD`=15, requester 2 alone holds `req` and never releases.
  - → `gnt`=4'b0100 for 15 cycles; `timeout` pulses once; `gnt` returns to 4'b0100 two cycles later.
- Release vs timeout:
  - `rel[owner]`=1 exactly on the 15th grant cycle → `gnt` drops and `timeout` stays 0.
- `ena` and stray release:
  - `ena` drops mid-grant → `gnt` low next edge, no `timeout`; no new grant while `ena`=0.
  - A non-owner `rel` pulse has no effect.
- Async reset:
  - Assert `rst_n` mid-grant between clock edges → `gnt`, `uio_oe`, `uio_out` go 0 immediately.
  - After release, the first grant goes to requester 0 if it is requesting.
